// File: rtl/adder_sched_pkg.sv
// Shared definitions for the two-requester adder job scheduler.
//   - Register map of the AXI-Lite adder slave (byte offsets).
//   - AXI OKAY response code.
//   - Scheduler FSM state encoding.
//   - Default per-phase timeout in clock cycles.
package adder_sched_pkg;

    localparam int unsigned RegOpA = 'h00;
    localparam int unsigned RegOpB = 'h04;
    localparam int unsigned RegSum = 'h08;
    localparam int unsigned RegOvf = 'h0C;

    localparam int unsigned RespOkay = 0;

    localparam int unsigned DefaultTimeout = 64;

    typedef enum logic [2:0] {
        StIdle,
        StWrA,
        StWbA,
        StWrB,
        StWbB,
        StRdSum,
        StRdOvf,
        StResp
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset; requester 0 wins the first tie
//   en_i   : arbitration enable; no grant is issued while low
//   req_i  : request vector
//   gnt_o  : one-hot grant (combinational); the pointer advances on any grant
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // Index of the most recently granted requester.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (gnt_o != 2'b00) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/adder_job_sched.sv
// Round-robin job scheduler for a single AXI-Lite adder slave.
// A granted job writes operand A (0x00) and B (0x04), reads the sum (0x08) and
// the carry flag (0x0C bit 0), then presents the result until accepted.
//   m1_axi_aclk / m1_axi_areset : clock and synchronous active-high reset
//   req_valid/req_ready/req_opa/req_opb : two requesters, one-cycle grant pulse
//   rsp_*                        : result channel (id, sum, carry, error)
//   m1_axi_aw*/w*/b*/ar*/r*      : AXI-Lite master towards the adder
module adder_job_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned TIMEOUT    = DefaultTimeout
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_opa,
    input  logic [2*DATA_WIDTH-1:0] req_opb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_ovf,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8:0]   m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [RESP_WIDTH-1:0]   m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [RESP_WIDTH-1:0]   m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    sched_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic id_q, id_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d, wdata_q, wdata_d, sum_q, sum_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic awvalid_q, awvalid_d, bready_q, bready_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic [1:0] req_ready_q, req_ready_d;
    logic rsp_valid_q, rsp_valid_d, ovf_q, ovf_d, err_q, err_d;

    logic arb_en, phase_expired, abort;
    logic [1:0] arb_gnt;

    // Grants are only taken in IDLE, so the pointer moves exactly once per job.
    assign arb_en = (state_q == StIdle);

    rr_arb2 u_arb (
        .clk_i (m1_axi_aclk),
        .rst_i (m1_axi_areset),
        .en_i  (arb_en),
        .req_i (req_valid),
        .gnt_o (arb_gnt)
    );

    assign phase_expired = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = phase_expired ? cnt_q : cnt_q + CntW'(1);
        id_d        = id_q;
        opb_d       = opb_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        req_ready_d = 2'b00;
        rsp_valid_d = rsp_valid_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        abort       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_gnt != 2'b00) begin
                    req_ready_d = arb_gnt;
                    id_d        = arb_gnt[1];
                    wdata_d     = arb_gnt[1] ? req_opa[DATA_WIDTH +: DATA_WIDTH]
                                             : req_opa[0 +: DATA_WIDTH];
                    opb_d       = arb_gnt[1] ? req_opb[DATA_WIDTH +: DATA_WIDTH]
                                             : req_opb[0 +: DATA_WIDTH];
                    awaddr_d    = ADDR_WIDTH'(RegOpA);
                    awvalid_d   = 1'b1;
                    bready_d    = 1'b1;
                    sum_d       = '0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    state_d     = StWrA;
                end
            end
            StWrA, StWrB: begin
                // Address and data are only released together.
                if (m1_axi_awready && m1_axi_wready) begin
                    awvalid_d = 1'b0;
                    state_d   = (state_q == StWrA) ? StWbA : StWbB;
                end else if (phase_expired) begin
                    abort = 1'b1;
                end
            end
            StWbA, StWbB: begin
                if (m1_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (m1_axi_bresp != RESP_WIDTH'(RespOkay)) begin
                        err_d = 1'b1;
                    end
                    if (state_q == StWbA) begin
                        awaddr_d  = ADDR_WIDTH'(RegOpB);
                        wdata_d   = opb_q;
                        awvalid_d = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = StWrB;
                    end else begin
                        araddr_d  = ADDR_WIDTH'(RegSum);
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = StRdSum;
                    end
                end else if (phase_expired) begin
                    abort = 1'b1;
                end
            end
            StRdSum, StRdOvf: begin
                // Drop arvalid once the address is taken; rready stays up for the data.
                if (arvalid_q && m1_axi_arready) begin
                    arvalid_d = 1'b0;
                end
                if (m1_axi_rvalid) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    if (m1_axi_rresp != RESP_WIDTH'(RespOkay)) begin
                        err_d = 1'b1;
                    end
                    if (state_q == StRdSum) begin
                        sum_d     = m1_axi_rdata;
                        araddr_d  = ADDR_WIDTH'(RegOvf);
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = StRdOvf;
                    end else begin
                        ovf_d       = m1_axi_rdata[0];
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end else if (phase_expired) begin
                    abort = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled phase ends the job with an error and a zeroed result.
        if (abort) begin
            awvalid_d   = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            err_d       = 1'b1;
            sum_d       = '0;
            ovf_d       = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            opb_q       <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            opb_q       <= opb_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = id_q;
    assign rsp_sum        = sum_q;
    assign rsp_ovf        = ovf_q;
    assign rsp_err        = err_q;
    assign m1_axi_awaddr  = awaddr_q;
    assign m1_axi_awvalid = awvalid_q;
    assign m1_axi_wdata   = wdata_q;
    assign m1_axi_wstrb   = '1;
    assign m1_axi_wvalid  = awvalid_q;
    assign m1_axi_bready  = bready_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_arvalid = arvalid_q;
    assign m1_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_job_sched.sv
// Self-checking bench for adder_job_sched with a behavioural AXI-Lite adder slave.
module tb_adder_job_sched;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned RW = 3;
    localparam logic [AW-1:0] NoAddr = 8'hFF;

    logic m1_axi_aclk = 1'b0;
    logic m1_axi_areset;
    logic [1:0] req_valid, req_ready;
    logic [2*DW-1:0] req_opa, req_opb;
    logic rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;
    logic [DW-1:0] rsp_sum;
    logic [AW-1:0] m1_axi_awaddr, m1_axi_araddr;
    logic m1_axi_awvalid, m1_axi_awready, m1_axi_wvalid, m1_axi_wready;
    logic m1_axi_bvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_arready;
    logic m1_axi_rvalid, m1_axi_rready;
    logic [DW-1:0] m1_axi_wdata, m1_axi_rdata;
    logic [DW/8:0] m1_axi_wstrb;
    logic [RW-1:0] m1_axi_bresp, m1_axi_rresp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic m_last;  // model: last granted requester

    always #5 m1_axi_aclk = ~m1_axi_aclk;

    adder_job_sched dut (
        .m1_axi_aclk    (m1_axi_aclk),
        .m1_axi_areset  (m1_axi_areset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opa        (req_opa),
        .req_opb        (req_opb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_sum        (rsp_sum),
        .rsp_ovf        (rsp_ovf),
        .rsp_err        (rsp_err),
        .m1_axi_awaddr  (m1_axi_awaddr),
        .m1_axi_awvalid (m1_axi_awvalid),
        .m1_axi_awready (m1_axi_awready),
        .m1_axi_wdata   (m1_axi_wdata),
        .m1_axi_wstrb   (m1_axi_wstrb),
        .m1_axi_wvalid  (m1_axi_wvalid),
        .m1_axi_wready  (m1_axi_wready),
        .m1_axi_bresp   (m1_axi_bresp),
        .m1_axi_bvalid  (m1_axi_bvalid),
        .m1_axi_bready  (m1_axi_bready),
        .m1_axi_araddr  (m1_axi_araddr),
        .m1_axi_arvalid (m1_axi_arvalid),
        .m1_axi_arready (m1_axi_arready),
        .m1_axi_rdata   (m1_axi_rdata),
        .m1_axi_rresp   (m1_axi_rresp),
        .m1_axi_rvalid  (m1_axi_rvalid),
        .m1_axi_rready  (m1_axi_rready)
    );

    // ---------------- behavioural adder slave ----------------
    logic [DW-1:0] s_rega, s_regb;
    logic [DW:0] s_full;
    int unsigned s_wcnt, s_rcnt;
    int unsigned cfg_aw_wait, cfg_r_wait;
    logic [AW-1:0] cfg_err_addr, cfg_drop_addr;
    logic [RW-1:0] cfg_err_code;
    logic [AW-1:0] aw_log[$];
    logic [AW-1:0] ar_log[$];
    logic s_wacc, s_racc;

    assign s_full = {1'b0, s_rega} + {1'b0, s_regb};
    assign s_wacc = m1_axi_awvalid && m1_axi_wvalid && !m1_axi_bvalid && (s_wcnt >= cfg_aw_wait);
    assign s_racc = m1_axi_arvalid && !m1_axi_rvalid && (s_rcnt >= cfg_r_wait);
    assign m1_axi_awready = s_wacc;
    assign m1_axi_wready  = s_wacc;
    assign m1_axi_arready = s_racc;

    always @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            m1_axi_bvalid <= 1'b0;
            m1_axi_bresp  <= '0;
            m1_axi_rvalid <= 1'b0;
            m1_axi_rresp  <= '0;
            m1_axi_rdata  <= '0;
            s_wcnt        <= 0;
            s_rcnt        <= 0;
        end else begin
            if (s_wacc) begin
                s_wcnt        <= 0;
                m1_axi_bvalid <= 1'b1;
                m1_axi_bresp  <= (m1_axi_awaddr == cfg_err_addr) ? cfg_err_code : '0;
                if (m1_axi_awaddr == 8'h00) s_rega <= m1_axi_wdata;
                else if (m1_axi_awaddr == 8'h04) s_regb <= m1_axi_wdata;
                aw_log.push_back(m1_axi_awaddr);
            end else begin
                if (m1_axi_awvalid && m1_axi_wvalid) s_wcnt <= s_wcnt + 1;
                if (m1_axi_bvalid && m1_axi_bready) m1_axi_bvalid <= 1'b0;
            end
            if (s_racc) begin
                s_rcnt <= 0;
                ar_log.push_back(m1_axi_araddr);
                if (m1_axi_araddr != cfg_drop_addr) begin
                    m1_axi_rvalid <= 1'b1;
                    m1_axi_rresp  <= (m1_axi_araddr == cfg_err_addr) ? cfg_err_code : '0;
                    if (m1_axi_araddr == 8'h08) m1_axi_rdata <= s_full[DW-1:0];
                    // Upper bits are noise: only bit 0 carries the flag.
                    else if (m1_axi_araddr == 8'h0C)
                        m1_axi_rdata <= (DW'($urandom) & ~DW'(1)) | DW'(s_full[DW]);
                    else m1_axi_rdata <= 32'hDEADBEEF;
                end
            end else begin
                if (m1_axi_arvalid) s_rcnt <= s_rcnt + 1;
                if (m1_axi_rvalid && m1_axi_rready) m1_axi_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rst_outputs(input string pfx);
        check({pfx, "_hs"}, {req_ready, rsp_valid, m1_axi_awvalid, m1_axi_wvalid,
                             m1_axi_bready, m1_axi_arvalid, m1_axi_rready}, '0);
        check({pfx, "_rsp"}, {rsp_err, rsp_ovf, rsp_sum}, '0);
        check({pfx, "_addr"}, {m1_axi_awaddr, m1_axi_araddr, m1_axi_wdata}, '0);
    endtask

    task automatic do_reset();
        req_valid     = 2'b00;
        rsp_ready     = 1'b0;
        m1_axi_areset = 1'b1;
        @(negedge m1_axi_aclk);
        check_rst_outputs("reset");
        @(negedge m1_axi_aclk);
        m1_axi_areset = 1'b0;
        m_last        = 1'b1;
    endtask

    // One job from request to accepted response; exp_lat 0 skips the latency check.
    task automatic run_job(input logic [1:0] valid, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input logic [DW-1:0] a1, input logic [DW-1:0] b1, input bit keep,
                           input int exp_lat, input bit exp_err, input bit exp_to);
        int cyc;
        logic gid;
        logic [DW:0] full;
        req_opa   = {a1, a0};
        req_opb   = {b1, b0};
        req_valid = valid;
        gid       = (valid == 2'b11) ? !m_last : valid[1];
        m_last    = gid;
        full      = gid ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 200) begin
            @(negedge m1_axi_aclk);
            cyc++;
        end
        if (req_ready == 2'b00) begin
            check("grant_wait", 0, 1);
            req_valid = 2'b00;
            return;
        end
        check("grant", req_ready, gid ? 2'b10 : 2'b01);
        if (!keep) begin
            // Operands are latched at grant; later input changes must not matter.
            req_valid = 2'b00;
            req_opa   = {$urandom, $urandom};
            req_opb   = {$urandom, $urandom};
        end
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge m1_axi_aclk);
            cyc++;
        end
        if (!rsp_valid) begin
            check("rsp_wait", 0, 1);
            return;
        end
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        if (exp_to) check("to_axi_idle", {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready,
                                          m1_axi_arvalid, m1_axi_rready}, '0);
        repeat ($urandom_range(0, 2)) @(negedge m1_axi_aclk);
        check("rsp_hold", rsp_valid, 1);
        check("rsp_id", rsp_id, gid);
        check("rsp_sum", rsp_sum, exp_to ? '0 : full[DW-1:0]);
        check("rsp_ovf", rsp_ovf, exp_to ? 1'b0 : full[DW]);
        check("rsp_err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        @(negedge m1_axi_aclk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        int cyc;
        int bad;
        int sel;
        logic [1:0] v;
        logic [DW-1:0] a0, b0, a1, b1;

        cfg_aw_wait   = 0;
        cfg_r_wait    = 0;
        cfg_err_addr  = NoAddr;
        cfg_drop_addr = NoAddr;
        cfg_err_code  = 3'd2;
        req_opa       = '0;
        req_opb       = '0;
        do_reset();
        check("wstrb", m1_axi_wstrb, 5'h1F);

        // Basic job from requester 0 and its register access order.
        aw_log.delete();
        ar_log.delete();
        run_job(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 8, 1'b0, 1'b0);
        check("wr_cnt", aw_log.size(), 2);
        if (aw_log.size() == 2) check("wr_addrs", {aw_log[0], aw_log[1]}, 16'h0004);
        check("rd_cnt", ar_log.size(), 2);
        if (ar_log.size() == 2) check("rd_addrs", {ar_log[0], ar_log[1]}, 16'h080C);

        // Carry out from requester 1.
        run_job(2'b10, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 8, 1'b0, 1'b0);

        // Both requesting continuously: alternation starting at 0 after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_job(2'b11, 32'(i), 32'd100, 32'(i * 1000), 32'd1, 1'b1, 8, 1'b0, 1'b0);
        end
        req_valid = 2'b00;

        // Sum read never answered: 64 cycles in RD_SUM after entering at cycle 4.
        cfg_drop_addr = 8'h08;
        run_job(2'b01, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 68, 1'b1, 1'b1);
        cfg_drop_addr = NoAddr;

        // Error response on the operand B write; sequence still completes.
        cfg_err_addr = 8'h04;
        cfg_err_code = 3'd2;
        run_job(2'b10, 32'd0, 32'd0, 32'd100, 32'd200, 1'b0, 8, 1'b1, 1'b0);
        cfg_err_addr = NoAddr;

        // Reset during WR_B abandons the job.
        req_opa   = {32'd9, 32'd11};
        req_opb   = {32'd9, 32'd22};
        req_valid = 2'b01;
        cyc = 0;
        while (!(m1_axi_awvalid && m1_axi_awaddr == 8'h04) && cyc < 50) begin
            @(negedge m1_axi_aclk);
            cyc++;
        end
        check("reach_wr_b", m1_axi_awvalid && m1_axi_awaddr == 8'h04, 1);
        m1_axi_areset = 1'b1;
        @(negedge m1_axi_aclk);
        check_rst_outputs("midrst");
        req_valid     = 2'b00;
        m1_axi_areset = 1'b0;
        m_last        = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge m1_axi_aclk);
            if (rsp_valid || m1_axi_awvalid || m1_axi_arvalid) bad++;
        end
        check("post_rst_quiet", bad, 0);

        // Randomised jobs: request patterns, operands, wait states and error responses.
        for (int i = 0; i < 16; i++) begin
            v  = 2'($urandom_range(1, 3));
            a0 = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
            b0 = $urandom;
            a1 = $urandom;
            b1 = (i % 3 == 0) ? 32'hFFFFFFFF : $urandom;
            cfg_aw_wait  = $urandom_range(0, 3);
            cfg_r_wait   = $urandom_range(0, 3);
            sel          = int'($urandom_range(0, 7));
            cfg_err_addr = (sel < 4) ? AW'(sel * 4) : NoAddr;
            cfg_err_code = RW'($urandom_range(1, 3));
            run_job(v, a0, b0, a1, b1, 1'b0, 0, sel < 4, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_job_sched.md
ADDER_JOB_SCHED -- requirements
Module: adder_job_sched

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand/result width; ADDR_WIDTH, 8, AXI address width; RESP_WIDTH, 3, AXI response width; TIMEOUT, 64, max cycles per AXI phase.
REQ-002 Ports SHALL be, clock and reset first:
- m1_axi_aclk  in  1  sole clock, all logic on rising edge
- m1_axi_areset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester job request
- req_ready  out  2  one-hot grant pulse; operands captured
- req_opa, req_opb  in  2*DATA_WIDTH  operands; requester i in slice [i*DW +: DW]
- rsp_valid  out  1  job result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  1  requester index of result
- rsp_sum  out  DATA_WIDTH  low DATA_WIDTH bits of A+B
- rsp_ovf  out  1  carry-out reported by adder
- rsp_err  out  1  non-OKAY response or timeout during job
- m1_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI-Lite write master; wstrb width DATA_WIDTH/8+1
- m1_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI-Lite read master
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high (m1_axi_areset).

Function
REQ-004 Block SHALL arbitrate two requesters round-robin onto one adder slave and sequence its AXI-Lite register map: 0x00 operand A, 0x04 operand B, 0x08 sum, 0x0C overflow (bit 0).
REQ-005 FSM states SHALL be IDLE, WR_A, WB_A, WR_B, WB_B, RD_SUM, RD_OVF, RESP.
REQ-006 IDLE: if any req_valid, grant the requester not granted last (if both valid), else the sole valid one; assert its req_ready for exactly one cycle, latch opa/opb/id, go to WR_A.
REQ-007 Priority pointer SHALL update only on grant; single requester repeatedly valid SHALL be granted back-to-back.
REQ-008 WR_x: drive awaddr, wdata, awvalid=wvalid=1, bready=1, wstrb all-ones; hold stable until awready and wready are sampled high in the same cycle, then deassert awvalid/wvalid and go to WB_x.
REQ-009 WB_x: keep bready=1 until bvalid sampled (including the handshake cycle itself); capture bresp; WB_A->WR_B, WB_B->RD_SUM.
REQ-010 RD_x: drive araddr, arvalid=1, rready=1 until rvalid sampled; capture rdata/rresp; deassert both next cycle; RD_SUM->RD_OVF->RESP.
REQ-011 rsp_sum SHALL be rdata of RD_SUM; rsp_ovf SHALL be rdata[0] of RD_OVF.
REQ-012 Any bresp/rresp != 0 SHALL set rsp_err for the job; sequence SHALL continue.
REQ-013 Per-phase counter SHALL reset on each state entry; reaching TIMEOUT in any WR/WB/RD state SHALL drop all AXI valids, set rsp_err=1, rsp_sum=0, rsp_ovf=0, go to RESP.
REQ-014 RESP: rsp_valid=1 with stable rsp_id/sum/ovf/err until rsp_ready sampled, then IDLE; no new grant before return to IDLE.
REQ-015 req_valid dropping after grant SHALL NOT affect the in-flight job.
REQ-016 Minimum job latency, grant to rsp_valid, SHALL be 8 cycles with zero-wait slave.

Reset
REQ-017 On m1_axi_areset: state IDLE; all AXI valid/ready outputs, req_ready, rsp_valid, rsp_err, rsp_ovf 0; rsp_sum, addr, wdata 0; pointer set so requester 0 wins first tie.
REQ-018 Reset mid-job SHALL abandon the job with no response and no further AXI activity.

Structure
REQ-019 Package adder_sched_pkg SHALL hold register offsets, OKAY response code, FSM state enum, default TIMEOUT.
REQ-020 Sub-module rr_arb2 (2-way round-robin arbiter, grant + pointer) SHALL be instantiated once.

Verification
REQ-021 Bench SHALL use a behavioural model of the adder slave (map per REQ-004) with configurable wait states and response codes.
REQ-022 req0 A=5, B=7 -> one response: id=0, sum=12, ovf=0, err=0; AXI writes at 0x00 then 0x04, reads 0x08 then 0x0C.
REQ-023 req1 A=0xFFFFFFFF, B=2 -> sum=0x00000001, ovf=1, err=0.
REQ-024 Both requesters valid continuously, 4 jobs -> grant order 0,1,0,1; ids match.
REQ-025 Slave never asserts rvalid on 0x08 -> after 64 cycles in RD_SUM: rsp_err=1, sum=0, AXI valids low.
REQ-026 Slave bresp=2 on 0x04 write -> job completes with correct sum, err=1; reset asserted during WR_B -> no rsp_valid, all outputs at reset values next cycle.
